// File: rtl/prach_pkg.sv
// Shared definitions for the PRACH half-band stages (decimator and interpolator):
// channel count, half-band coefficients, sample types and the output saturator.
package prach_pkg;

  localparam int NUM_CH_USED = 24;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [17:0] coe_t;

  // fi(1,18,17) outer and inner taps; the centre tap (0.5) is applied as a plain copy.
  localparam coe_t HB2_COE [2] = '{-18'sd4249, 18'sd37013};

  typedef struct packed {
    logic       sync;
    logic       dv;
    logic [7:0] chn;
  } side_t;

  function automatic sample_t sat16(input logic signed [19:0] v);
    sample_t res;
    if (v > 20'sd32767) begin
      res = 16'sd32767;
    end else if (v < -20'sd32768) begin
      res = -16'sd32768;
    end else begin
      res = v[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/prach_hb2_int_ch_if.sv
// TDM sample bus for the channelised half-band interpolator: one input stream,
// two polyphase output lanes with their sideband and the channel-order error flag.
interface prach_hb2_int_ch_if;
  import prach_pkg::*;

  sample_t    din_dq;
  logic       din_dv;
  logic [7:0] din_chn;
  logic       sync_in;

  sample_t    dout_dp1;
  sample_t    dout_dp2;
  logic       dout_dv;
  logic [7:0] dout_chn;
  logic       sync_out;
  logic       err_chn;

  modport master (
    output din_dq, din_dv, din_chn, sync_in,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );

  modport slave (
    input  din_dq, din_dv, din_chn, sync_in,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );

endinterface

// File: rtl/prach_hb2_int_ch_delay.sv
// Generic fixed-length register delay for sideband bundles.
module prach_hb2_int_ch_delay #(
  parameter int WIDTH = 10,
  parameter int DELAY = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DELAY-1];

endmodule

// File: rtl/prach_hb2_int_ch.sv
// Channelised half-band interpolator-by-2: each accepted TDM sample yields an even
// (FIR) and an odd (centre-tap) polyphase output, LATENCY cycles later.
module prach_hb2_int_ch
  import prach_pkg::*;
(
  input logic               clk,
  input logic               rst,
  prach_hb2_int_ch_if.slave bus
);

  localparam int         LATENCY   = 6;
  localparam int         XD_LEN    = 3 * NUM_CH_USED + 1;
  localparam logic [7:0] LAST_SLOT = 8'(NUM_CH_USED - 1);

  // ---------------------------------------------------------------- delay line
  sample_t xd [XD_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the delay line is reset explicitly; its contents feed the first
      // post-reset outputs, so stale history must not survive a reset.
      for (int i = 0; i < XD_LEN; i++) xd[i] <= '0;
    end else if (bus.din_dv) begin
      // NOTE: non-blocking updates make every tap take its neighbour's pre-edge value.
      xd[0] <= bus.din_dq;
      for (int i = 1; i < XD_LEN; i++) xd[i] <= xd[i-1];
    end
  end

  // ---------------------------------------------------------------- arithmetic pipeline
  logic signed [16:0] s0_q, s1_q;
  logic signed [34:0] p0_q, p1_q;
  logic signed [35:0] r_q;
  sample_t            y_q, dp1_q;
  sample_t            ctr_q [4];
  sample_t            dp2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q  <= '0;
      s1_q  <= '0;
      p0_q  <= '0;
      p1_q  <= '0;
      r_q   <= '0;
      y_q   <= '0;
      dp1_q <= '0;
      for (int i = 0; i < 4; i++) ctr_q[i] <= '0;
      dp2_q <= '0;
    end else begin
      s0_q  <= 17'(xd[0]) + 17'(xd[3*NUM_CH_USED]);
      s1_q  <= 17'(xd[NUM_CH_USED]) + 17'(xd[2*NUM_CH_USED]);
      p0_q  <= 35'(s0_q) * 35'(HB2_COE[0]);
      p1_q  <= 35'(s1_q) * 35'(HB2_COE[1]);
      r_q   <= 36'(p0_q) + 36'(p1_q);
      // Shift by 16 rather than 17 gives the interpolator its gain of 2.
      y_q   <= sat16(r_q[35:16]);
      dp1_q <= y_q;
      // Centre tap is taken from the same snapshot and carried alongside the FIR.
      ctr_q[0] <= xd[NUM_CH_USED];
      for (int i = 1; i < 4; i++) ctr_q[i] <= ctr_q[i-1];
      dp2_q <= ctr_q[3];
    end
  end

  // ---------------------------------------------------------------- slot counter
  logic [7:0] slot_q;
  logic       chn_bad;
  logic       err_q;

  always_comb begin
    // NOTE: default assignment first so no path leaves chn_bad holding a latch.
    chn_bad = 1'b0;
    if (bus.din_dv) begin
      chn_bad = bus.sync_in ? (bus.din_chn != 8'd0) : (bus.din_chn != slot_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (chn_bad) err_q <= 1'b1;
      if (bus.din_dv) begin
        if (bus.sync_in)             slot_q <= 8'd1;
        else if (slot_q == LAST_SLOT) slot_q <= 8'd0;
        else                          slot_q <= slot_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------- sideband
  side_t                side_in, side_out;
  logic [LATENCY-1:0]   flush_sr;
  logic                 flush_ok;

  assign side_in = '{sync: bus.sync_in, dv: bus.din_dv, chn: bus.din_chn};

  prach_hb2_int_ch_delay #(
    .WIDTH ($bits(side_t)),
    .DELAY (LATENCY)
  ) u_side_dly (
    .clk   (clk),
    .rst_n (1'b1),
    .din   (side_in),
    .dout  (side_out)
  );

  // The shared delay block is never reset, so its output is masked until every
  // stage has been refilled with post-reset sideband.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_sr <= '0;
    else     flush_sr <= {flush_sr[LATENCY-2:0], 1'b1};
  end

  assign flush_ok = flush_sr[LATENCY-1];

  assign bus.dout_dp1 = dp1_q;
  assign bus.dout_dp2 = dp2_q;
  assign bus.dout_dv  = side_out.dv & flush_ok;
  assign bus.dout_chn = flush_ok ? side_out.chn : 8'd0;
  assign bus.sync_out = side_out.sync & flush_ok;
  assign bus.err_chn  = err_q;

endmodule

// File: tb/tb_prach_hb2_int_ch.sv
// Directed bench for prach_hb2_int_ch: impulse, DC, saturation, gapped traffic,
// channel-order error and mid-frame reset, against a per-cycle reference model.
module tb_prach_hb2_int_ch;
  import prach_pkg::*;

  localparam int N    = NUM_CH_USED;
  localparam int LAT  = 6;
  localparam int MAXC = 4096;
  localparam int NONE = 99999;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prach_hb2_int_ch_if bus ();

  prach_hb2_int_ch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Per-cycle stimulus record, model expectations and observed outputs.
  logic       r_dv   [MAXC];
  logic [7:0] r_chn  [MAXC];
  logic       r_sync [MAXC];
  int         e_dp1  [MAXC];
  int         e_dp2  [MAXC];
  int         o_dp1  [MAXC];
  int         o_dp2  [MAXC];
  int         cyc         = 0;
  int         release_cyc = 0;

  int   m_xd [3*N+1];
  logic m_err;
  int   m_cnt;
  int   fr   [N];

  int imp_dp1 [5] = '{-1063, 9253, 9253, -1063, 0};
  int imp_dp2 [5] = '{0, 16384, 0, 0, 0};
  int sat_seq [4] = '{32767, -32768, -32768, 32767};
  int sat_neg [4] = '{-32768, 32767, 32767, -32768};

  task automatic model_clear();
    for (int i = 0; i <= 3*N; i++) m_xd[i] = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step(input int idx, input logic dv, input logic [7:0] chn,
                            input int dq, input logic sync);
    longint r, y;
    int     s0, s1;
    if (dv) begin
      if (sync) begin
        if (chn != 8'd0) m_err = 1'b1;
        m_cnt = 1;
      end else begin
        if (int'(chn) != m_cnt) m_err = 1'b1;
        m_cnt = (m_cnt == N-1) ? 0 : m_cnt + 1;
      end
      for (int i = 3*N; i > 0; i--) m_xd[i] = m_xd[i-1];
      m_xd[0] = dq;
      s0 = m_xd[0] + m_xd[3*N];
      s1 = m_xd[N] + m_xd[2*N];
      r  = longint'(s0) * -4249 + longint'(s1) * 37013;
      y  = r >>> 16;
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      e_dp1[idx] = int'(y);
      e_dp2[idx] = m_xd[N];
    end
  endtask

  task automatic observe();
    int k;
    k = cyc - LAT;
    check("err_chn", bus.err_chn, m_err);
    if (k >= release_cyc) begin
      check("dout_dv", bus.dout_dv, r_dv[k]);
      if (r_dv[k]) begin
        check("dout_chn", bus.dout_chn, r_chn[k]);
        check("sync_out", bus.sync_out, r_sync[k]);
        check("dout_dp1", bus.dout_dp1, e_dp1[k]);
        check("dout_dp2", bus.dout_dp2, e_dp2[k]);
        o_dp1[k] = int'(bus.dout_dp1);
        o_dp2[k] = int'(bus.dout_dp2);
      end
    end else begin
      check("dout_dv_flush", bus.dout_dv, 0);
    end
  endtask

  task automatic step(input logic dv, input logic [7:0] chn, input int dq, input logic sync);
    @(negedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL record_overflow got=%0d exp<%0d", cyc, MAXC);
      $fatal(1, "record overflow");
    end
    observe();
    bus.din_dv  = dv;
    bus.din_chn = chn;
    bus.din_dq  = 16'(dq);
    bus.sync_in = sync;
    r_dv[cyc]   = dv;
    r_chn[cyc]  = chn;
    r_sync[cyc] = sync;
    model_step(cyc, dv, chn, dq, sync);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'hFF, 0, 1'b0);
  endtask

  task automatic frame(input int gap_pct, input int bad_slot);
    for (int c = 0; c < N; c++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct)
        step(1'b0, 8'hFF, int'($urandom_range(65535)), 1'($urandom_range(1)));
      step(1'b1, (c == bad_slot) ? 8'(c + 1) : 8'(c), fr[c], c == 0);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst         = 1'b1;
      bus.din_dv  = 1'b0;
      bus.sync_in = 1'b0;
      #1;
      check("rst_dp1", bus.dout_dp1, 0);
      check("rst_dp2", bus.dout_dp2, 0);
      check("rst_dv", bus.dout_dv, 0);
      check("rst_chn", bus.dout_chn, 0);
      check("rst_sync", bus.sync_out, 0);
      check("rst_err", bus.err_chn, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    release_cyc = cyc;
    r_dv[cyc]   = 1'b0;
    cyc++;
  endtask

  task automatic impulse_test(input string tag);
    int f0;
    f0 = cyc;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < N; c++) fr[c] = 0;
      if (k == 0) fr[5] = 16384;
      frame(0, -1);
    end
    idle(LAT + 1);
    for (int k = 0; k < 5; k++) begin
      check({tag, "_ch5_dp1"}, o_dp1[f0 + N*k + 5], imp_dp1[k]);
      check({tag, "_ch5_dp2"}, o_dp2[f0 + N*k + 5], imp_dp2[k]);
      for (int c = 0; c < N; c++) begin
        if (c != 5) begin
          check({tag, "_other_dp1"}, o_dp1[f0 + N*k + c], 0);
          check({tag, "_other_dp2"}, o_dp2[f0 + N*k + c], 0);
        end
      end
    end
  endtask

  task automatic dc_test();
    int f0;
    f0 = cyc;
    for (int c = 0; c < N; c++) fr[c] = 16384;
    for (int k = 0; k < 6; k++) frame(0, -1);
    idle(LAT + 1);
    for (int k = 3; k < 6; k++) begin
      for (int c = 0; c < N; c++) begin
        check("dc_dp1", o_dp1[f0 + N*k + c], 16382);
        check("dc_dp2", o_dp2[f0 + N*k + c], 16384);
      end
    end
  endtask

  task automatic sat_test();
    int f0;
    f0 = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < N; c++) fr[c] = 0;
      fr[0] = sat_seq[k % 4];
      fr[1] = sat_neg[k % 4];
      frame(0, -1);
    end
    idle(LAT + 1);
    check("sat_pos_f5", o_dp1[f0 + N*5 + 0], 32767);
    check("sat_pos_f9", o_dp1[f0 + N*9 + 0], 32767);
    check("sat_neg_f5", o_dp1[f0 + N*5 + 1], -32768);
    check("sat_neg_f9", o_dp1[f0 + N*9 + 1], -32768);
    check("sat_ch0_f7", o_dp1[f0 + N*7 + 0], -32768);
  endtask

  task automatic rand_test();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < N; c++) fr[c] = int'($urandom_range(65535)) - 32768;
      frame(25, -1);
    end
    idle(LAT + 1);
  endtask

  task automatic err_test();
    for (int c = 0; c < N; c++) fr[c] = int'($urandom_range(2000)) - 1000;
    check("err_pre", bus.err_chn, 0);
    frame(0, 7);
    check("err_set", bus.err_chn, 1);
    frame(0, -1);
    frame(0, -1);
    check("err_sticky", bus.err_chn, 1);
  endtask

  task automatic midreset_test();
    for (int c = 0; c < 12; c++) step(1'b1, 8'(c), int'($urandom_range(65535)) - 32768, c == 0);
    do_reset(3);
    check("err_cleared", bus.err_chn, 0);
    impulse_test("rst_imp");
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      o_dp1[i] = NONE;
      o_dp2[i] = NONE;
      r_dv[i]  = 1'b0;
    end
    bus.din_dv  = 1'b0;
    bus.din_chn = 8'd0;
    bus.din_dq  = '0;
    bus.sync_in = 1'b0;
    model_clear();
    do_reset(3);
    impulse_test("imp");
    dc_test();
    sat_test();
    rand_test();
    err_test();
    midreset_test();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
